block_memory_sequencer: RTL and testbench
=========================================

BLOCK_MEMORY_SEQUENCER -- requirements
Module: block_memory_sequencer

Interface
REQ-001 Parameter BASE_ADDR, default 0: bus address of word 0 of the target block memory.
REQ-002 Parameter BRAM_DEPTH, default 256: entries in the target block memory.
REQ-003 Parameter BRAM_WIDTH, default 33: bits per entry; N_CHUNKS = ceil(BRAM_WIDTH/16); EW = $clog2(BRAM_DEPTH).
REQ-004 Parameter TIMEOUT, default 64: cycles to wait for a bus response before aborting.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset; synchronous, active-low.
REQ-007 req_valid  input  1  user request present.
REQ-008 req_ready  output  1  sequencer can accept a request.
REQ-009 req_rw  input  1  1 = write entry, 0 = read entry.
REQ-010 req_entry  input  EW  target entry index.
REQ-011 req_wdata  input  BRAM_WIDTH  write data.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_rdata  output  BRAM_WIDTH  assembled read data; 0 for writes.
REQ-014 resp_err  output  1  qualified by resp_valid; 1 = timeout abort.
REQ-015 addr_o, wdata_o, rdata_o  output  16 each  bus request to chain head.
REQ-016 rw_o, valid_o  output  1 each  bus request to chain head.
REQ-017 addr_i, wdata_i, rdata_i  input  16 each  bus response from chain tail.
REQ-018 rw_i, valid_i  input  1 each  bus response from chain tail.

Function
REQ-019 Entry is stored as N_CHUNKS 16-bit words; chunk k holds bits [16k+15:16k], chunk 0 least significant.
REQ-020 Bus address of chunk k of entry e SHALL be BASE_ADDR + k*BRAM_DEPTH + e, 16-bit wrap.
REQ-021 States IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-022 req_ready = 1 only in IDLE; handshake req_valid && req_ready latches rw, entry, wdata, clears chunk counter, moves to ISSUE.
REQ-023 ISSUE: valid_o = 1 for exactly one cycle with addr_o per REQ-020, rw_o = latched rw, wdata_o = chunk k of write data (0 on reads), rdata_o = 0; then WAIT.
REQ-024 valid_o SHALL be 0 in every state other than ISSUE; addr_o/wdata_o/rw_o hold between issues.
REQ-025 WAIT: response matches when valid_i && addr_i == issued addr && rw_i == issued rw; non-matching valid_i ignored.
REQ-026 On match in a read, rdata_i stored into chunk k of read buffer; bits above BRAM_WIDTH-1 discarded.
REQ-027 On match with k < N_CHUNKS-1: k increments, next state ISSUE; with k = N_CHUNKS-1: next state DONE.
REQ-028 Write chunk N_CHUNKS-1 bits above BRAM_WIDTH-1 SHALL be driven 0.
REQ-029 Timeout counter clears on each ISSUE, increments each WAIT cycle; at TIMEOUT with no match: abort to DONE with error.
REQ-030 Match and timeout in same cycle: match wins.
REQ-031 DONE: resp_valid = 1 one cycle, resp_rdata = buffer (reads) or 0 (writes), resp_err set per outcome; then IDLE.
REQ-032 resp_rdata holds until next DONE; partial read data on abort SHALL be presented as-is.
REQ-033 Minimum request-to-resp_valid latency, zero-delay chain: 2*N_CHUNKS+1 cycles; one request in flight at most.

Reset
REQ-034 rst_n low at a clock edge: state IDLE, req_ready 1 after release, resp_valid/resp_err/valid_o/rw_o 0, addr_o/wdata_o/rdata_o 0, resp_rdata 0, counters 0.
REQ-035 Reset mid-transaction abandons it without resp_valid; late bus responses after reset ignored in IDLE.

Verification
REQ-036 Write entry 5, data 33'h1_2345_6789 -> bus writes 0x0005/0x6789, 0x0105/0x2345, 0x0205/0x0001 in order; resp_valid, resp_err 0.
REQ-037 Read entry 5 after REQ-036 through real block_memory -> reads at 0x0005, 0x0105, 0x0205; resp_rdata 33'h1_2345_6789, resp_err 0.
REQ-038 Chain never returns valid_i on read entry 3 -> resp_valid with resp_err 1 exactly TIMEOUT WAIT cycles after the single ISSUE; req_ready 1 next cycle.
REQ-039 Inject valid_i with addr 0x0099 during WAIT of chunk 0 -> ignored; sequence completes normally on matching response.
REQ-040 Assert rst_n low during WAIT of chunk 1 -> no resp_valid, all outputs per REQ-034; subsequent read of entry 5 returns 33'h1_2345_6789.
REQ-041 Back-to-back requests with req_valid held high -> second accepted only after first resp_valid; never two valid_o without an intervening match or timeout.

Source files
------------

// File: rtl/block_memory_sequencer.sv
// Sequences one wide block-memory entry access as N_CHUNKS 16-bit bus transactions
// on a request/response chain, with a per-chunk response timeout.
module block_memory_sequencer #(
  parameter int BASE_ADDR  = 0,
  parameter int BRAM_DEPTH = 256,
  parameter int BRAM_WIDTH = 33,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_rw,
  input  logic [$clog2(BRAM_DEPTH)-1:0] req_entry,
  input  logic [BRAM_WIDTH-1:0]         req_wdata,
  output logic                          resp_valid,
  output logic [BRAM_WIDTH-1:0]         resp_rdata,
  output logic                          resp_err,
  output logic [15:0]                   addr_o,
  output logic [15:0]                   wdata_o,
  output logic [15:0]                   rdata_o,
  output logic                          rw_o,
  output logic                          valid_o,
  input  logic [15:0]                   addr_i,
  input  logic [15:0]                   wdata_i,
  input  logic [15:0]                   rdata_i,
  input  logic                          rw_i,
  input  logic                          valid_i
);

  localparam int EW       = $clog2(BRAM_DEPTH);
  localparam int N_CHUNKS = (BRAM_WIDTH + 15) / 16;
  localparam int PW       = N_CHUNKS * 16;
  localparam int CW       = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int TW       = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] LAST_CHUNK = CW'(N_CHUNKS - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   chunk_q;
  logic [TW-1:0]   tmo_q;
  logic [EW-1:0]   entry_q;
  logic [PW-1:0]   wdata_q;
  logic [PW-1:0]   rbuf;
  logic [PW-1:0]   rbuf_merge;
  logic [PW-1:0]   req_wpad;
  logic [CW-1:0]   chunk_nxt;
  logic            accept;
  logic            match;
  logic            unused_bits;

  // Chunks of one entry live in consecutive BRAM_DEPTH-sized banks; address wraps at 16 bits.
  function automatic logic [15:0] chunk_addr(input logic [CW-1:0] k, input logic [EW-1:0] e);
    return 16'(BASE_ADDR) + 16'(k) * 16'(BRAM_DEPTH) + 16'(e);
  endfunction

  assign req_wpad  = PW'(req_wdata);
  assign chunk_nxt = chunk_q + CW'(1);
  assign accept    = (state == IDLE) && req_valid && req_ready;
  assign match     = (state == WAIT) && valid_i && (addr_i == addr_o) && (rw_i == rw_o);
  assign rdata_o   = '0;

  always_comb begin
    rbuf_merge = rbuf;
    rbuf_merge[16*int'(chunk_q) +: 16] = rdata_i;
  end

  // Response write-data and read padding above BRAM_WIDTH are intentionally dropped.
  assign unused_bits = ^{wdata_i, rbuf_merge};

  always_ff @(posedge clk) begin
    if (accept) begin
      entry_q <= req_entry;
      wdata_q <= req_wpad;
      rbuf    <= '0;
    end else if (match && !rw_o) begin
      rbuf <= rbuf_merge;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      valid_o    <= 1'b0;
      rw_o       <= 1'b0;
      addr_o     <= '0;
      wdata_o    <= '0;
      chunk_q    <= '0;
      tmo_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            chunk_q   <= '0;
            tmo_q     <= '0;
            valid_o   <= 1'b1;
            rw_o      <= req_rw;
            addr_o    <= chunk_addr('0, req_entry);
            wdata_o   <= req_rw ? req_wpad[15:0] : 16'h0000;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          valid_o <= 1'b0;
          tmo_q   <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          // A matching response wins over a timeout expiring in the same cycle.
          if (match) begin
            if (chunk_q == LAST_CHUNK) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= rw_o ? '0 : rbuf_merge[BRAM_WIDTH-1:0];
              state      <= DONE;
            end else begin
              chunk_q <= chunk_nxt;
              valid_o <= 1'b1;
              addr_o  <= chunk_addr(chunk_nxt, entry_q);
              wdata_o <= rw_o ? wdata_q[16*int'(chunk_nxt) +: 16] : 16'h0000;
              state   <= ISSUE;
            end
          end else if (tmo_q == TMO_LAST) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= rw_o ? '0 : rbuf[BRAM_WIDTH-1:0];
            state      <= DONE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        DONE: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_memory_sequencer.sv
// Bench for block_memory_sequencer: a behavioural block memory on the bus chain plus
// an entry-level reference model, driven by directed and randomized requests.
module tb_block_memory_sequencer;

  localparam int BASE_ADDR  = 0;
  localparam int BRAM_DEPTH = 256;
  localparam int BRAM_WIDTH = 33;
  localparam int TIMEOUT    = 64;
  localparam int N_CHUNKS   = (BRAM_WIDTH + 15) / 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_rw;
  logic [7:0]  req_entry;
  logic [32:0] req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [32:0] resp_rdata;
  logic [15:0] addr_o, wdata_o, rdata_o;
  logic        rw_o, valid_o;
  logic [15:0] addr_i = 16'h0, wdata_i = 16'h0, rdata_i = 16'h0;
  logic        rw_i = 1'b0, valid_i = 1'b0;

  block_memory_sequencer #(
    .BASE_ADDR(BASE_ADDR), .BRAM_DEPTH(BRAM_DEPTH), .BRAM_WIDTH(BRAM_WIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_entry(req_entry), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o), .rw_o(rw_o), .valid_o(valid_o),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] bus_mem [0:65535];
  logic [32:0] ref_mem [0:255];

  int   resp_delay   = 0;
  int   drop_after   = -1;
  int   n_served     = 0;
  int   bogus_n      = 0;
  bit   inject_bogus = 1'b0;
  bit   pend         = 1'b0;
  bit   outstanding  = 1'b0;
  int   pend_cnt     = 0;
  logic [15:0] pend_addr, pend_wdata;
  logic        pend_rw;

  logic [15:0] log_addr[$];
  logic [15:0] log_wd[$];
  logic        log_rw[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, got, exp);
    end
  endtask

  // Block memory on the chain: answers each issue after resp_delay extra cycles,
  // optionally preceded by two non-matching responses, or not at all when dropped.
  always @(negedge clk) begin
    valid_i = 1'b0;
    if (rst_n === 1'b0) outstanding = 1'b0;
    if (resp_valid === 1'b1) outstanding = 1'b0;
    if (pend && pend_cnt == 0) begin
      valid_i = 1'b1;
      addr_i  = pend_addr;
      rw_i    = pend_rw;
      wdata_i = pend_wdata;
      if (pend_rw) begin
        bus_mem[pend_addr] = pend_wdata;
        rdata_i = 16'($urandom);
      end else begin
        rdata_i = bus_mem[pend_addr];
      end
      pend = 1'b0;
      outstanding = 1'b0;
    end else begin
      if (pend) pend_cnt--;
      if (bogus_n > 0) begin
        valid_i = 1'b1;
        rdata_i = 16'($urandom);
        wdata_i = 16'($urandom);
        if (bogus_n == 2) begin
          addr_i = 16'h0099;
          rw_i   = pend_rw;
        end else begin
          addr_i = pend_addr;
          rw_i   = ~pend_rw;
        end
        bogus_n--;
      end
    end
    if (valid_o === 1'b1) begin
      chk("single_issue_in_flight", outstanding, 0);
      chk("rdata_o_zero", rdata_o, 0);
      outstanding = 1'b1;
      log_addr.push_back(addr_o);
      log_rw.push_back(rw_o);
      log_wd.push_back(wdata_o);
      if (drop_after < 0 || n_served < drop_after) begin
        pend       = 1'b1;
        pend_cnt   = resp_delay;
        pend_addr  = addr_o;
        pend_rw    = rw_o;
        pend_wdata = wdata_o;
        n_served++;
        if (inject_bogus) begin
          bogus_n = 2;
          inject_bogus = 1'b0;
        end
      end
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_rw.delete();
    log_wd.delete();
  endtask

  task automatic do_req(input string tag, input bit rw, input logic [7:0] e, input logic [32:0] wd,
                        input int delay, input bit bogus, input int drop,
                        output logic [32:0] rd, output bit err, output int lat);
    int w;
    resp_delay = delay;
    inject_bogus = bogus;
    drop_after = drop;
    n_served = 0;
    clear_log();
    w = 0;
    while (req_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_ready_wait"}, w < 100, 1);
    req_valid = 1'b1;
    req_rw    = rw;
    req_entry = e;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    req_entry = 8'($urandom);
    req_wdata = {1'($urandom), 32'($urandom)};
    req_rw    = 1'($urandom);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_resp_wait"}, lat < 1000, 1);
    rd  = resp_rdata;
    err = resp_err;
  endtask

  task automatic verify_tx(input string tag, input bit rw, input logic [7:0] e,
                           input logic [32:0] wd, input int n);
    logic [63:0] wpad;
    wpad = 64'(wd);
    chk({tag, "_ntx"}, log_addr.size(), n);
    for (int k = 0; k < n && k < log_addr.size(); k++) begin
      chk({tag, "_addr"}, log_addr[k], 64'((BASE_ADDR + k * BRAM_DEPTH + int'(e)) & 16'hFFFF));
      chk({tag, "_rw"}, log_rw[k], rw);
      chk({tag, "_wdata"}, log_wd[k], rw ? ((wpad >> (16 * k)) & 64'hFFFF) : 64'h0);
    end
  endtask

  task automatic run_op(input string tag, input bit rw, input logic [7:0] e, input logic [32:0] wd,
                        input int delay, input bit bogus);
    logic [32:0] rd, exp_rd;
    bit err;
    int lat;
    exp_rd = rw ? 33'h0 : ref_mem[e];
    do_req(tag, rw, e, wd, delay, bogus, -1, rd, err, lat);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_latency"}, lat, N_CHUNKS * (delay + 2) + 1);
    verify_tx(tag, rw, e, wd, N_CHUNKS);
    if (rw) ref_mem[e] = wd;
    @(negedge clk);
    chk({tag, "_pulse_one_cycle"}, resp_valid, 0);
    chk({tag, "_ready_after"}, req_ready, 1);
    chk({tag, "_rdata_hold"}, resp_rdata, exp_rd);
  endtask

  // Read that aborts after n_ok chunks completed; unreceived chunks read as zero.
  task automatic run_abort(input string tag, input logic [7:0] e, input int delay,
                           input int drop, input int n_ok);
    logic [32:0] rd, exp_rd;
    logic [63:0] mask;
    bit err;
    int lat;
    mask = (64'd1 << (16 * n_ok)) - 64'd1;
    exp_rd = 33'(64'(ref_mem[e]) & mask);
    do_req(tag, 1'b0, e, 33'h0, delay, 1'b0, drop, rd, err, lat);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, err, 1);
    chk({tag, "_latency"}, lat, n_ok * (delay + 2) + TIMEOUT + 2);
    verify_tx(tag, 1'b0, e, 33'h0, n_ok + 1);
    @(negedge clk);
    chk({tag, "_pulse_one_cycle"}, resp_valid, 0);
    chk({tag, "_ready_after"}, req_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_valid_o"}, valid_o, 0);
    chk({tag, "_rw_o"}, rw_o, 0);
    chk({tag, "_addr_o"}, addr_o, 0);
    chk({tag, "_wdata_o"}, wdata_o, 0);
    chk({tag, "_rdata_o"}, rdata_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 65536; a++) bus_mem[a] = 16'h0;
    for (int a = 0; a < 256; a++) ref_mem[a] = 33'h0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_rw = 1'b0;
    req_entry = 8'h0;
    req_wdata = 33'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);
    chk("por_ready_after_release", req_ready, 1);

    run_op("w5", 1'b1, 8'd5, 33'h1_2345_6789, 0, 1'b0);
    if (log_addr.size() == 3) begin
      chk("w5_addr0", log_addr[0], 16'h0005);
      chk("w5_addr1", log_addr[1], 16'h0105);
      chk("w5_addr2", log_addr[2], 16'h0205);
      chk("w5_data0", log_wd[0], 16'h6789);
      chk("w5_data1", log_wd[1], 16'h2345);
      chk("w5_data2", log_wd[2], 16'h0001);
    end
    run_op("r5", 1'b0, 8'd5, 33'h0, 0, 1'b0);
    run_op("bogus_resp", 1'b0, 8'd5, 33'h0, 2, 1'b1);
    run_op("bogus_resp_wr", 1'b1, 8'd7, 33'h0_DEAD_BEEF, 3, 1'b1);
    run_abort("timeout_r3", 8'd3, 0, 0, 0);
    run_abort("partial_abort", 8'd5, 1, 1, 1);
    run_op("match_at_last_wait", 1'b0, 8'd5, 33'h0, TIMEOUT - 1, 1'b0);
    run_abort("match_too_late", 8'd5, TIMEOUT, -1, 0);

    begin
      int nis, w, seen;
      resp_delay = 3;
      drop_after = -1;
      inject_bogus = 1'b0;
      n_served = 0;
      clear_log();
      req_valid = 1'b1;
      req_rw = 1'b0;
      req_entry = 8'd5;
      @(negedge clk);
      req_valid = 1'b0;
      nis = 0;
      w = 0;
      while (nis < 2 && w < 100) begin
        if (valid_o === 1'b1) nis++;
        if (nis < 2) begin
          @(negedge clk);
          w++;
        end
      end
      chk("midrst_reach_chunk1", nis, 2);
      @(negedge clk);
      rst_n = 1'b0;
      seen = 0;
      repeat (2) begin
        @(negedge clk);
        if (resp_valid === 1'b1) seen++;
      end
      check_reset_outputs("midrst");
      rst_n = 1'b1;
      repeat (8) begin
        @(negedge clk);
        if (resp_valid === 1'b1 || valid_o === 1'b1) seen++;
      end
      chk("midrst_no_activity", seen, 0);
    end
    run_op("post_rst_r5", 1'b0, 8'd5, 33'h0, 0, 1'b0);

    begin
      int nresp, cyc, ready_hi;
      logic [32:0] wa, wb;
      wa = 33'h1_A5A5_0F0F;
      wb = 33'h0_1357_9BDF;
      resp_delay = 0;
      drop_after = -1;
      n_served = 0;
      clear_log();
      req_valid = 1'b1;
      req_rw = 1'b1;
      req_entry = 8'd10;
      req_wdata = wa;
      nresp = 0;
      cyc = 0;
      ready_hi = 0;
      while (nresp < 2 && cyc < 200) begin
        @(negedge clk);
        cyc++;
        if (resp_valid === 1'b1) begin
          nresp++;
          if (nresp == 1) begin
            req_entry = 8'd11;
            req_wdata = wb;
          end else begin
            req_valid = 1'b0;
          end
        end else if (req_ready === 1'b1 && nresp == 0) begin
          ready_hi++;
        end
      end
      chk("b2b_responses", nresp, 2);
      chk("b2b_ready_low_in_flight", ready_hi, 0);
      chk("b2b_second_done_cycle", cyc, 2 * (2 * N_CHUNKS + 1) + 1);
      chk("b2b_ntx", log_addr.size(), 2 * N_CHUNKS);
      if (log_addr.size() == 2 * N_CHUNKS) begin
        chk("b2b_first_addr", log_addr[0], 16'h000A);
        chk("b2b_second_addr", log_addr[N_CHUNKS], 16'h000B);
      end
      ref_mem[10] = wa;
      ref_mem[11] = wb;
      @(negedge clk);
      run_op("b2b_rd10", 1'b0, 8'd10, 33'h0, 0, 1'b0);
      run_op("b2b_rd11", 1'b0, 8'd11, 33'h0, 1, 1'b0);
    end

    for (int i = 0; i < 16; i++) begin
      bit rw, bg;
      logic [7:0] e;
      logic [32:0] wd;
      int d, sel;
      rw  = 1'($urandom);
      sel = $urandom_range(0, 3);
      e   = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'(40 + $urandom_range(0, 5));
      wd  = {1'($urandom), 32'($urandom)};
      d   = $urandom_range(0, 3);
      bg  = (d >= 2) && 1'($urandom);
      run_op($sformatf("rnd%0d", i), rw, e, wd, d, bg);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
